// File: rtl/alu_seq_ctrl.sv
// Operation sequencer: fetches opcode and operand pair from RAM,
// drives the external ALU and writes each result to a destination table.
module alu_seq_ctrl #(
  parameter int DW = 16,
  parameter int AW = 8,
  parameter int OPW = 5,
  parameter int OP_BASE = 100,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 199,
  parameter logic [OPW-1:0] HALT_OP = 5'h1f,
  parameter int MAX_OPS = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] douta,
  input  logic [DW-1:0] doutb,
  input  logic [DW-1:0] alu_res,
  output logic [AW-1:0] addr1,
  output logic [AW-1:0] addr2,
  output logic [DW-1:0] data_out1,
  output logic          wea,
  output logic [OPW-1:0] op,
  output logic [DW-1:0] opnd_a,
  output logic [DW-1:0] opnd_b,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] op_count
);

  typedef enum logic [2:0] {
    IDLE,
    OP_REQ,
    OP_LAT,
    SRC_REQ,
    SRC_LAT,
    EXEC,
    WRITE,
    DONE
  } state_t;

  localparam logic [AW-1:0] OP_B  = AW'(OP_BASE);
  localparam logic [AW-1:0] SRC_B = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST_B = AW'(DST_BASE);
  localparam logic [AW:0]   MAX_N = (AW+1)'(MAX_OPS);

  state_t state, state_d;

  logic [AW-1:0] op_ptr;
  logic [AW-1:0] src_ptr;
  logic [AW-1:0] dst_ptr;
  logic          is_halt;
  logic          last;

  assign is_halt = (douta[OPW-1:0] == HALT_OP);
  assign last = (({1'b0, op_count} + (AW+1)'(1)) == MAX_N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: if (start) state_d = OP_REQ;
        OP_REQ:  state_d = OP_LAT;
        OP_LAT:  state_d = is_halt ? DONE : SRC_REQ;
        SRC_REQ: state_d = SRC_LAT;
        SRC_LAT: state_d = EXEC;
        EXEC:    state_d = WRITE;
        WRITE:   state_d = last ? DONE : OP_REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Status flags follow the next state so they stay registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_ptr    <= OP_B;
      src_ptr   <= SRC_B;
      dst_ptr   <= DST_B;
      op_count  <= '0;
      addr1     <= '0;
      addr2     <= '0;
      data_out1 <= '0;
      wea       <= 1'b0;
      op        <= '0;
      opnd_a    <= '0;
      opnd_b    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      wea  <= 1'b0;
      busy <= !(state_d inside {IDLE, DONE});
      done <= (state_d == DONE);
      if (!abort) begin
        unique case (state)
          IDLE, DONE: begin
            if (start) begin
              op_ptr   <= OP_B;
              src_ptr  <= SRC_B;
              dst_ptr  <= DST_B;
              op_count <= '0;
              addr1    <= OP_B;
            end
          end
          OP_LAT: begin
            op <= douta[OPW-1:0];
            if (!is_halt) begin
              addr1 <= src_ptr;
              addr2 <= src_ptr + AW'(1);
            end
          end
          SRC_LAT: begin
            opnd_a <= douta;
            opnd_b <= doutb;
          end
          EXEC: begin
            data_out1 <= alu_res;
            addr1     <= dst_ptr;
            wea       <= 1'b1;
          end
          WRITE: begin
            op_ptr   <= op_ptr + AW'(1);
            src_ptr  <= src_ptr + AW'(2);
            dst_ptr  <= dst_ptr + AW'(1);
            op_count <= op_count + AW'(1);
            if (!last) addr1 <= op_ptr + AW'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: RAM and ALU models plus a table-walking
// reference of the operation sequence.
module tb_alu_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start [2];
  logic        abort [2];
  logic        wea [2];
  logic        busy [2];
  logic        done [2];
  logic [15:0] douta [2];
  logic [15:0] doutb [2];
  logic [15:0] alu_res [2];
  logic [15:0] data_out1 [2];
  logic [15:0] opnd_a [2];
  logic [15:0] opnd_b [2];
  logic [7:0]  addr1 [2];
  logic [7:0]  addr2 [2];
  logic [7:0]  op_count [2];
  logic [4:0]  op [2];
  logic [15:0] mem [2][256];

  localparam int OPB [2]  = '{100, 100};
  localparam int SRCB [2] = '{0, 254};
  localparam int DSTB [2] = '{199, 255};
  localparam int MAXN [2] = '{64, 2};

  int tests = 0;
  int fails = 0;

  int w_addr [$];
  int w_data [$];
  int w_edge [$];
  int e_addr [$];
  int e_data [$];
  int e_edge [$];
  int done_edge;
  int e_done;
  bit dbl;

  function automatic logic [15:0] alu_f(logic [4:0] o, logic [15:0] a,
                                        logic [15:0] b);
    case (o[1:0])
      2'd0:    return a ^ b;
      2'd1:    return a + b;
      2'd2:    return a - b;
      default: return a & b;
    endcase
  endfunction

  assign alu_res[0] = alu_f(op[0], opnd_a[0], opnd_b[0]);
  assign alu_res[1] = alu_f(op[1], opnd_a[1], opnd_b[1]);

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      douta[d] <= mem[d][addr1[d]];
      doutb[d] <= mem[d][addr2[d]];
      if (wea[d]) mem[d][addr1[d]] = data_out1[d];
    end
  end

  alu_seq_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .douta(douta[0]), .doutb(doutb[0]), .alu_res(alu_res[0]),
    .addr1(addr1[0]), .addr2(addr2[0]), .data_out1(data_out1[0]),
    .wea(wea[0]), .op(op[0]), .opnd_a(opnd_a[0]), .opnd_b(opnd_b[0]),
    .busy(busy[0]), .done(done[0]), .op_count(op_count[0])
  );

  alu_seq_ctrl #(.SRC_BASE(254), .DST_BASE(255), .MAX_OPS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .douta(douta[1]), .doutb(doutb[1]), .alu_res(alu_res[1]),
    .addr1(addr1[1]), .addr2(addr2[1]), .data_out1(data_out1[1]),
    .wea(wea[1]), .op(op[1]), .opnd_a(opnd_a[1]), .opnd_b(opnd_b[1]),
    .busy(busy[1]), .done(done[1]), .op_count(op_count[1])
  );

  // Walks the tables as the sequencer should; edges counted from start.
  task automatic model_run(input int d);
    logic [15:0] m [256];
    logic [4:0]  o;
    logic [15:0] a, b, r;
    int ad;
    for (int i = 0; i < 256; i++) m[i] = mem[d][i];
    e_addr.delete(); e_data.delete(); e_edge.delete();
    e_done = 6 * MAXN[d];
    for (int n = 0; n < MAXN[d]; n++) begin
      o = m[(OPB[d] + n) % 256][4:0];
      if (o == 5'h1f) begin
        e_done = 6 * n + 2;
        break;
      end
      a = m[(SRCB[d] + 2 * n) % 256];
      b = m[(SRCB[d] + 2 * n + 1) % 256];
      r = alu_f(o, a, b);
      ad = (DSTB[d] + n) % 256;
      e_addr.push_back(ad);
      e_data.push_back(int'(r));
      e_edge.push_back(6 * n + 6);
      m[ad] = r;
    end
  endtask

  task automatic run_collect(input int d, input int budget);
    bit prev;
    prev = 1'b0;
    w_addr.delete(); w_data.delete(); w_edge.delete();
    done_edge = -1;
    dbl = 1'b0;
    @(negedge clk);
    start[d] = 1'b1;
    @(posedge clk);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      start[d] = 1'b0;
      if (wea[d]) begin
        w_addr.push_back(int'(addr1[d]));
        w_data.push_back(int'(data_out1[d]));
        w_edge.push_back(k + 1);
        if (prev) dbl = 1'b1;
      end
      prev = wea[d];
      if (done[d]) begin
        done_edge = k;
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic fill_rand(input int d);
    for (int i = 0; i < 256; i++) mem[d][i] = 16'($urandom);
  endtask

  task automatic set_op(input int d, input int a, input logic [4:0] o);
    logic [15:0] w;
    w = 16'($urandom);
    w[4:0] = o;
    mem[d][a] = w;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) mem[0][i] = 16'h0;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    tests++;
    if (busy[0] !== 1'b1) begin
      fails++;
      $display("FAIL rst_busy_run: got %0b want 1", busy[0]);
    end
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if ({addr1[d], addr2[d], data_out1[d], wea[d], op[d], opnd_a[d],
           opnd_b[d], busy[d], done[d], op_count[d]} !== '0) begin
        fails++;
        $display("FAIL rst_outs%0d: got a1=%0h a2=%0h d=%0h w=%0b op=%0h bsy=%0b dn=%0b cnt=%0d want all 0",
                 d, addr1[d], addr2[d], data_out1[d], wea[d], op[d],
                 busy[d], done[d], op_count[d]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    tests++;
    if (busy[0] !== 1'b0 || wea[0] !== 1'b0 || addr1[0] !== 8'd0) begin
      fails++;
      $display("FAIL rst_idle: got busy=%0b wea=%0b a1=%0d want 0 0 0",
               busy[0], wea[0], addr1[0]);
    end
  endtask

  task automatic test_single_halt();
    for (int i = 0; i < 256; i++) mem[0][i] = 16'h0;
    mem[0][100] = 16'h0001;
    mem[0][0] = 16'd3;
    mem[0][1] = 16'd4;
    mem[0][101] = 16'h001f;
    run_collect(0, 100);
    tests++;
    if (w_addr.size() != 1) begin
      fails++;
      $display("FAIL single_nwr: got %0d want 1", w_addr.size());
    end
    tests++;
    if (w_addr.size() == 0 || w_addr[0] != 199 || w_data[0] != 7 ||
        w_edge[0] != 6) begin
      fails++;
      $display("FAIL single_wr: got n=%0d a=%0d d=%0d e=%0d want a=199 d=7 e=6",
               w_addr.size(), w_addr.size() ? w_addr[0] : -1,
               w_addr.size() ? w_data[0] : -1,
               w_addr.size() ? w_edge[0] : -1);
    end
    tests++;
    if (done_edge != 8 || op_count[0] !== 8'd1 || busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL single_done: got edge=%0d cnt=%0d busy=%0b want 8 1 0",
               done_edge, op_count[0], busy[0]);
    end
    tests++;
    if (dbl || mem[0][199] !== 16'd7) begin
      fails++;
      $display("FAIL single_mem: got dbl=%0b m199=%0d want 0 7",
               dbl, mem[0][199]);
    end
  endtask

  task automatic test_three_ops();
    fill_rand(0);
    for (int i = 0; i < 3; i++) set_op(0, 100 + i, 5'($urandom_range(0, 30)));
    set_op(0, 103, 5'h1f);
    for (int r = 0; r < 2; r++) begin
      model_run(0);
      run_collect(0, 200);
      tests++;
      if (w_addr.size() != 3 || e_addr.size() != 3) begin
        fails++;
        $display("FAIL three_nwr%0d: got %0d want 3", r, w_addr.size());
      end
      for (int i = 0; i < e_addr.size() && i < w_addr.size(); i++) begin
        tests++;
        if (w_addr[i] != e_addr[i] || w_data[i] != e_data[i] ||
            w_edge[i] != e_edge[i]) begin
          fails++;
          $display("FAIL three_wr%0d_%0d: got a=%0d d=%0h e=%0d want a=%0d d=%0h e=%0d",
                   r, i, w_addr[i], w_data[i], w_edge[i],
                   e_addr[i], e_data[i], e_edge[i]);
        end
      end
      tests++;
      if (done_edge != e_done || op_count[0] !== 8'd3 || dbl) begin
        fails++;
        $display("FAIL three_done%0d: got edge=%0d cnt=%0d dbl=%0b want %0d 3 0",
                 r, done_edge, op_count[0], dbl, e_done);
      end
    end
  endtask

  task automatic test_abort();
    int nwr;
    int bad;
    logic [15:0] keep;
    fill_rand(0);
    set_op(0, 100, 5'd1);
    set_op(0, 101, 5'd2);
    set_op(0, 102, 5'd3);
    set_op(0, 103, 5'h1f);
    keep = mem[0][200];
    nwr = 0;
    bad = 0;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (wea[0]) begin
        nwr++;
        if (addr1[0] !== 8'd199) bad++;
      end
      if (k == 10) begin
        abort[0] = 1'b0;
        tests++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0 || wea[0] !== 1'b0) begin
          fails++;
          $display("FAIL abort_idle: got busy=%0b done=%0b wea=%0b want 0 0 0",
                   busy[0], done[0], wea[0]);
        end
      end
      if (k == 9) abort[0] = 1'b1;
    end
    tests++;
    if (nwr != 1 || bad != 0 || mem[0][200] !== keep) begin
      fails++;
      $display("FAIL abort_writes: got n=%0d bad=%0d m200=%0h want 1 0 %0h",
               nwr, bad, mem[0][200], keep);
    end
    tests++;
    if (op_count[0] !== 8'd1 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      fails++;
      $display("FAIL abort_cnt: got cnt=%0d busy=%0b done=%0b want 1 0 0",
               op_count[0], busy[0], done[0]);
    end
  endtask

  task automatic test_max_wrap();
    fill_rand(1);
    for (int i = 0; i < 4; i++) set_op(1, 100 + i, 5'($urandom_range(0, 30)));
    model_run(1);
    run_collect(1, 100);
    tests++;
    if (w_addr.size() != 2) begin
      fails++;
      $display("FAIL wrap_nwr: got %0d want 2", w_addr.size());
    end
    for (int i = 0; i < e_addr.size() && i < w_addr.size(); i++) begin
      tests++;
      if (w_addr[i] != e_addr[i] || w_data[i] != e_data[i] ||
          w_edge[i] != e_edge[i]) begin
        fails++;
        $display("FAIL wrap_wr%0d: got a=%0d d=%0h e=%0d want a=%0d d=%0h e=%0d",
                 i, w_addr[i], w_data[i], w_edge[i],
                 e_addr[i], e_data[i], e_edge[i]);
      end
    end
    tests++;
    if (done_edge != 12 || op_count[1] !== 8'd2 || busy[1] !== 1'b0) begin
      fails++;
      $display("FAIL wrap_done: got edge=%0d cnt=%0d busy=%0b want 12 2 0",
               done_edge, op_count[1], busy[1]);
    end
  endtask

  task automatic test_random();
    int h;
    for (int it = 0; it < 4; it++) begin
      fill_rand(0);
      for (int i = 0; i < 64; i++) set_op(0, 100 + i, 5'($urandom_range(0, 30)));
      h = (it == 3) ? 64 : $urandom_range(0, 6);
      if (h < 64) set_op(0, 100 + h, 5'h1f);
      model_run(0);
      run_collect(0, 500);
      tests++;
      if (w_addr.size() != e_addr.size()) begin
        fails++;
        $display("FAIL rand%0d_nwr: got %0d want %0d",
                 it, w_addr.size(), e_addr.size());
      end
      for (int i = 0; i < e_addr.size() && i < w_addr.size(); i++) begin
        tests++;
        if (w_addr[i] != e_addr[i] || w_data[i] != e_data[i] ||
            w_edge[i] != e_edge[i]) begin
          fails++;
          $display("FAIL rand%0d_wr%0d: got a=%0d d=%0h e=%0d want a=%0d d=%0h e=%0d",
                   it, i, w_addr[i], w_data[i], w_edge[i],
                   e_addr[i], e_data[i], e_edge[i]);
        end
      end
      tests++;
      if (done_edge != e_done || op_count[0] != e_addr.size() || dbl ||
          busy[0] !== 1'b0) begin
        fails++;
        $display("FAIL rand%0d_done: got edge=%0d cnt=%0d dbl=%0b busy=%0b want %0d %0d 0 0",
                 it, done_edge, op_count[0], dbl, busy[0],
                 e_done, e_addr.size());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      abort[d] = 1'b0;
      for (int i = 0; i < 256; i++) mem[d][i] = 16'h0;
    end
    test_reset();
    test_single_halt();
    test_three_ops();
    test_abort();
    test_max_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Parametrised operation sequencer for the ALU datapath. It fetches opcodes from an opcode table and operand pairs from a source table, both held in a shared dual-port synchronous-read RAM. It presents each opcode and operand pair to the external ALU, then writes the result to an auto-incrementing destination table. It runs on `start` until a halt opcode or an operation limit, supports `abort`, and reports `busy`/`done`.

## Interface
Parameters:
- DW, 16, data word width
- AW, 8, RAM address width
- OPW, 5, opcode width (low OPW bits of the opcode word)
- OP_BASE, 100, first opcode address
- SRC_BASE, 0, first operand-pair address
- DST_BASE, 199, first result address
- HALT_OP, 5'h1f, opcode that ends the run
- MAX_OPS, 64, operation limit per run (1..2^AW-1)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a run; sampled only in IDLE and DONE
- abort  in  1  synchronous; forces IDLE at the next edge
- douta  in  DW  RAM port A read data
- doutb  in  DW  RAM port B read data
- alu_res  in  DW  combinational ALU result of (op, opnd_a, opnd_b)
- addr1  out  AW  RAM port A address (read/write)
- addr2  out  AW  RAM port B address (read only)
- data_out1  out  DW  RAM port A write data
- wea  out  1  RAM port A write enable
- op  out  OPW  current opcode to the ALU
- opnd_a, opnd_b  out  DW  current operands to the ALU
- busy  out  1  run in progress
- done  out  1  run finished; level output
- op_count  out  AW  results written in the current or last run

## Operation
- The RAM has synchronous read: dout in cycle k+1 reflects the address registered in cycle k. All outputs are registered.
- Internal pointers op_ptr, src_ptr and dst_ptr are AW bits and wrap modulo 2^AW. addr2 = src_ptr+1, also modulo 2^AW.
- States and transitions:
  - IDLE: busy=0. On start: pointers load their base values, op_count<=0, done<=0, addr1<=OP_BASE, go to OP_REQ.
  - OP_REQ: wait one cycle; go to OP_LAT.
  - OP_LAT: op<=douta[OPW-1:0].
    - If that value equals HALT_OP, go to DONE. op_count is not incremented.
    - Otherwise addr1<=src_ptr and addr2<=src_ptr+1, then go to SRC_REQ.
  - SRC_REQ: wait; go to SRC_LAT.
  - SRC_LAT: opnd_a<=douta, opnd_b<=doutb; go to EXEC.
  - EXEC: data_out1<=alu_res, addr1<=dst_ptr, wea<=1; go to WRITE.
  - WRITE: wea<=0; op_ptr+=1, src_ptr+=2, dst_ptr+=1, op_count+=1.
    - If op_count+1==MAX_OPS, go to DONE.
    - Otherwise addr1<=op_ptr+1, go to OP_REQ.
  - DONE: done=1, busy=0. On start, behave exactly as start in IDLE (restart from the base addresses).
- busy=1 in every state except IDLE and DONE.
- start while busy is ignored.
- abort has priority over all transitions: state<=IDLE, wea<=0, done<=0. Pointers and op_count hold their values. A write whose wea is already high completes in the current cycle.
- Upper DW-OPW bits of the opcode word are ignored.

## Timing
- Reset: state=IDLE, all outputs 0, pointers at their base values.
- Each non-halt operation takes 6 cycles: OP_REQ, OP_LAT, SRC_REQ, SRC_LAT, EXEC, WRITE.
- Take edge e0 as the edge that samples start. wea is high during the cycle after edge e5, and the write happens at edge e6.
- A halt opcode at operation n: done rises 2 cycles after the OP_REQ of operation n.
- wea is never high for more than one consecutive cycle.
- addr1 holds dst_ptr throughout the wea cycle.
- op, opnd_a and opnd_b are stable from SRC_LAT+1 through WRITE.

## Test plan
- Reset: assert rst_n=0 mid-run -> all outputs 0 immediately, state IDLE. Release reset, give no start -> busy stays 0.
- Single op then halt: mem[100]=0x01, mem[0]=3, mem[1]=4, mem[101]=0x1f, ALU model = add. Pulse start -> write 7 to addr 199, wea high exactly 1 cycle, 6 cycles after the start edge. Then done=1, op_count=1.
- Three ops then halt -> reads pairs (0,1), (2,3), (4,5); results written to 199, 200, 201; op_count=3. Pulse start again -> identical sequence from the base addresses.
- MAX_OPS=2 with no halt in the table -> exactly 2 writes (199, 200), then done=1, op_count=2.
- Abort asserted in SRC_LAT of operation 2 -> next cycle IDLE, busy=0, done=0, no write to 200, op_count=1.
- Wrap: SRC_BASE=254, DST_BASE=255, two ops -> operand pairs (254,255) then (0,1); results written to 255 then 0.
